// File: rtl/apb_mst_arbiter_pkg.sv
// Shared APB types and sequencer state encoding.
// No logic; types only.
// No flow control.
package apb_mst_arbiter_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [STRB_WIDTH-1:0] strb_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_mst_arbiter_rr_arbiter.sv
// Round-robin pick: first set request after i_last, wrapping.
// Latency: combinational.
// No backpressure; caller decides when the grant is consumed.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int          w_pos;
  logic [IW-1:0] w_sel;

  // Scan N positions starting just after the previous winner.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_pos = 0;
    w_sel = '0;
    for (int k = 1; k <= N; k++) begin
      w_pos = (int'(i_last) + k) % N;
      w_sel = IW'(w_pos);
      if (!o_any && i_req[w_sel]) begin
        o_any        = 1'b1;
        o_gnt[w_sel] = 1'b1;
        o_idx        = w_sel;
      end
    end
  end

endmodule

// File: rtl/apb_mst_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ requesters.
// Latency: accept T, SETUP T+1, ACCESS T+2.., response pulse the cycle after PREADY/timeout.
// Backpressure: req_ready only in IDLE; one transfer in flight, wait states stall all requesters.
module apb_mst_arbiter
  import apb_mst_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  addr_t [NUM_REQ-1:0]  req_addr,
  input  logic [NUM_REQ-1:0]   req_write,
  input  data_t [NUM_REQ-1:0]  req_wdata,
  input  strb_t [NUM_REQ-1:0]  req_strb,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output data_t                rsp_rdata,
  output logic                 rsp_err,
  output logic                 PSEL,
  output logic                 PENABLE,
  output addr_t                PADDR,
  output logic                 PWRITE,
  output data_t                PWDATA,
  output strb_t                PSTRB,
  input  logic                 PREADY,
  input  data_t                PRDATA,
  input  logic                 PSLVERR
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  apb_state_e          r_state;
  logic [IW-1:0]       r_last;
  logic [CW-1:0]       r_wait_cnt;
  logic                r_psel;
  logic                r_penable;
  addr_t               r_paddr;
  logic                r_pwrite;
  data_t               r_pwdata;
  strb_t               r_pstrb;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  data_t               r_rsp_rdata;
  logic                r_rsp_err;

  logic [NUM_REQ-1:0]  w_gnt;
  logic [IW-1:0]       w_idx;
  logic                w_any;
  logic                w_timeout;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .i_req  (req_valid),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  // This ACCESS cycle is the TIMEOUT_CYC-th one without PREADY.
  assign w_timeout = (TIMEOUT_CYC != 0) && ((int'({1'b0, r_wait_cnt}) + 1) == TIMEOUT_CYC);

  // Grant is visible only while idle and out of reset, so a held reset never accepts.
  assign req_ready = (r_state == IDLE && PRESETn) ? w_gnt : '0;

  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PADDR     = r_paddr;
  assign PWRITE    = r_pwrite;
  assign PWDATA    = r_pwdata;
  assign PSTRB     = r_pstrb;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  // Sequencer FSM: grant/capture in IDLE, one SETUP cycle, ACCESS until PREADY or timeout.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= IDLE;
      r_last      <= IW'(NUM_REQ - 1);
      r_wait_cnt  <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_paddr    <= req_addr[w_idx];
            r_pwrite   <= req_write[w_idx];
            r_pwdata   <= req_wdata[w_idx];
            r_pstrb    <= req_write[w_idx] ? req_strb[w_idx] : '0;
            r_last     <= w_idx;
            r_wait_cnt <= '0;
            r_psel     <= 1'b1;
            r_state    <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            r_rsp_valid <= NUM_REQ'(1) << r_last;
            r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
            r_rsp_err   <= PSLVERR;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_state     <= IDLE;
          end else if (w_timeout) begin
            r_rsp_valid <= NUM_REQ'(1) << r_last;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mst_arbiter.sv
// Self-checking bench: directed protocol cases, then randomized traffic vs a transaction model.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Slave model inserts wait states / errors and keeps its own memory.
module tb_apb_mst_arbiter;
  import apb_mst_arbiter_pkg::*;

  localparam int NR = 3;
  localparam int TO = 16;
  localparam int NCMD = 20;

  typedef struct {
    bit    wr;
    addr_t a;
    data_t d;
    strb_t s;
  } cmd_t;

  logic              PCLK;
  logic              PRESETn;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  addr_t [NR-1:0]    req_addr;
  logic [NR-1:0]     req_write;
  data_t [NR-1:0]    req_wdata;
  strb_t [NR-1:0]    req_strb;
  logic [NR-1:0]     rsp_valid;
  data_t             rsp_rdata;
  logic              rsp_err;
  logic              PSEL, PENABLE, PWRITE;
  addr_t             PADDR;
  data_t             PWDATA;
  strb_t             PSTRB;
  logic              PREADY;
  data_t             PRDATA;
  logic              PSLVERR;

  int    n_chk = 0;
  int    n_err = 0;
  int    slv_waits = 0;
  bit    slv_err = 1'b0;
  bit    slv_rnd = 1'b0;
  int    acc_k = 0;
  data_t slv_mem [16];
  data_t ref_mem [16];
  cmd_t  cq [NR][$];

  apb_mst_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] oh(input int i);
    return NR'(1) << i;
  endfunction

  // Round-robin rule: first valid requester after the last winner, wrapping; -1 if none.
  function automatic int pick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++) begin
      int p;
      p = (last + k) % NR;
      if (((v >> p) & NR'(1)) != '0) return p;
    end
    return -1;
  endfunction

  function automatic data_t merge(input data_t old, input data_t d, input strb_t s);
    data_t o;
    o = old;
    for (int b = 0; b < 4; b++)
      if (((s >> b) & 4'd1) != 4'd0) o[b*8 +: 8] = d[b*8 +: 8];
    return o;
  endfunction

  // APB slave: ready after slv_waits stalled ACCESS cycles; garbage whenever not ready.
  initial begin
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    forever begin
      @(posedge PCLK); #1;
      if (PRESETn && PSEL && PENABLE) begin
        acc_k++;
        if (acc_k == 1 && slv_rnd) begin
          slv_waits = int'($urandom_range(0, 3));
          slv_err   = ($urandom_range(0, 5) == 0);
        end
        if (acc_k > slv_waits) begin
          PREADY  = 1'b1;
          PSLVERR = slv_err;
          PRDATA  = PWRITE ? data_t'($urandom) : slv_mem[PADDR[5:2]];
          if (PWRITE && !slv_err) slv_mem[PADDR[5:2]] = merge(slv_mem[PADDR[5:2]], PWDATA, PSTRB);
        end else begin
          PREADY = 1'b0; PRDATA = data_t'($urandom); PSLVERR = 1'($urandom);
        end
      end else begin
        acc_k = 0;
        PREADY = 1'($urandom); PRDATA = data_t'($urandom); PSLVERR = 1'($urandom);
      end
    end
  end

  // One directed transfer from requester r; called 1ns after a rising edge with the DUT idle.
  task automatic xfer(input int r, input bit wr, input addr_t a, input data_t wd, input strb_t st,
                      input int waits, input bit serr, input data_t exp_rd, input bit exp_err,
                      input int exp_acc);
    int n;
    bit stable;
    slv_waits = waits; slv_err = serr;
    req_valid = '0; req_valid[r] = 1'b1;
    req_write[r] = wr; req_addr[r] = a; req_wdata[r] = wd; req_strb[r] = st;
    @(negedge PCLK);
    check("x_ready", 32'(req_ready), 32'(oh(r)));
    check("x_idle_psel", 32'(PSEL), 32'(0));
    @(posedge PCLK); #1;
    req_valid = '1; req_write[r] = ~wr; req_addr[r] = ~a; req_wdata[r] = ~wd; req_strb[r] = ~st;
    @(negedge PCLK);
    check("x_setup", 32'({PSEL, PENABLE}), 32'h2);
    check("x_ready_busy", 32'(req_ready), 32'(0));
    check("x_paddr", PADDR, a);
    check("x_pwrite", 32'(PWRITE), 32'(wr));
    check("x_pwdata", PWDATA, wd);
    check("x_pstrb", 32'(PSTRB), wr ? 32'(st) : 32'(0));
    @(posedge PCLK); #1;
    req_valid = '0;
    n = 0; stable = 1'b1;
    @(negedge PCLK);
    while (PSEL && PENABLE && n < 40) begin
      n++;
      if (PADDR !== a || PWDATA !== wd || PWRITE !== wr) stable = 1'b0;
      @(negedge PCLK);
    end
    check("x_acc_len", 32'(n), 32'(exp_acc));
    check("x_stable", 32'(stable), 32'(1));
    check("x_rsp_vld", 32'(rsp_valid), 32'(oh(r)));
    check("x_rdata", rsp_rdata, exp_rd);
    check("x_err", 32'(rsp_err), 32'(exp_err));
    check("x_done_psel", 32'({PSEL, PENABLE}), 32'(0));
    @(negedge PCLK);
    check("x_rsp_pulse", 32'(rsp_valid), 32'(0));
    check("x_paddr_hold", PADDR, a);
    @(posedge PCLK); #1;
  endtask

  initial begin
    int m_last, m_ph, m_g, p, cyc, prev, n_rsp, total;
    logic [NR-1:0] exp_rv, exp_rdy;
    data_t exp_rd;
    bit exp_re;
    cmd_t m_cur, c;

    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
    for (int i = 0; i < 16; i++) slv_mem[i] = '0;

    // ---- reset state ----
    PRESETn = 1'b1;
    #2 PRESETn = 1'b0;
    req_valid = '1;
    #10;
    check("rst_psel", 32'(PSEL), 32'(0));
    check("rst_penable", 32'(PENABLE), 32'(0));
    check("rst_paddr", PADDR, 32'(0));
    check("rst_pwrite", 32'(PWRITE), 32'(0));
    check("rst_pwdata", PWDATA, 32'(0));
    check("rst_pstrb", 32'(PSTRB), 32'(0));
    check("rst_ready", 32'(req_ready), 32'(0));
    check("rst_rsp_vld", 32'(rsp_valid), 32'(0));
    check("rst_rdata", rsp_rdata, 32'(0));
    check("rst_err", 32'(rsp_err), 32'(0));
    req_valid = '0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // ---- directed transfers ----
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0, 1'b0, 1);
    slv_mem[8] = 32'h12345678;
    xfer(1, 1'b0, 32'h20, 32'hCAFEF00D, 4'hA, 3, 1'b0, 32'h12345678, 1'b0, 4);
    xfer(1, 1'b1, 32'h3FC, 32'h55AA55AA, 4'hF, 0, 1'b1, 32'h0, 1'b1, 1);
    xfer(0, 1'b0, 32'h40, 32'h0, 4'hF, 1000, 1'b0, 32'h0, 1'b1, TO);
    xfer(2, 1'b0, 32'h10, 32'h0, 4'h0, 1, 1'b0, 32'hDEADBEEF, 1'b0, 2);
    m_last = 2;

    // ---- fairness: requesters 0 and 1 continuously valid ----
    slv_waits = 0; slv_err = 1'b0;
    req_valid = 3'b011; req_write = '0; req_addr = '0;
    cyc = 0; prev = 0;
    for (int k = 0; k < 6; k++) begin
      int w;
      w = 0;
      @(negedge PCLK); cyc++;
      while (req_ready == '0 && w < 20) begin @(negedge PCLK); cyc++; w++; end
      check("fair_wait", 32'(w < 20), 32'(1));
      p = pick(req_valid, m_last);
      check("fair_gnt", 32'(req_ready), 32'(oh(p)));
      if (k > 0) check("fair_gap", 32'(cyc - prev), 32'(3));
      prev = cyc; m_last = p;
    end
    @(posedge PCLK); #1;
    req_valid = '0;
    repeat (5) @(posedge PCLK);
    #1;

    // ---- reset during ACCESS ----
    slv_waits = 1000;
    req_valid = 3'b001; req_write[0] = 1'b1; req_addr[0] = 32'h44; req_wdata[0] = 32'h11;
    @(negedge PCLK);
    @(posedge PCLK); #1; req_valid = '0;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    check("mid_access", 32'({PSEL, PENABLE}), 32'h3);
    #2 PRESETn = 1'b0;
    req_valid = '1; req_write[0] = 1'b0; req_addr[0] = 32'h0;
    #1;
    check("mid_rst_psel", 32'({PSEL, PENABLE}), 32'(0));
    check("mid_rst_paddr", PADDR, 32'(0));
    check("mid_rst_ready", 32'(req_ready), 32'(0));
    slv_waits = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge PCLK);
      check("mid_rst_rsp", 32'(rsp_valid), 32'(0));
    end
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("post_rst_gnt", 32'(req_ready), 32'(oh(0)));
    @(posedge PCLK); #1; req_valid = '0;
    @(negedge PCLK); check("post_rst_rsp1", 32'(rsp_valid), 32'(0));
    @(negedge PCLK); check("post_rst_rsp2", 32'(rsp_valid), 32'(0));
    @(negedge PCLK); check("post_rst_rsp3", 32'(rsp_valid), 32'(oh(0)));
    m_last = 0;
    @(posedge PCLK); #1;

    // ---- randomized traffic vs transaction model ----
    for (int i = 0; i < 16; i++) begin
      slv_mem[i] = data_t'(i) * 32'h01010101;
      ref_mem[i] = data_t'(i) * 32'h01010101;
    end
    slv_rnd = 1'b1;
    for (int r = 0; r < NR; r++)
      for (int n = 0; n < NCMD; n++) begin
        c.wr = 1'($urandom);
        c.a  = addr_t'($urandom_range(0, 15)) << 2;
        c.d  = data_t'($urandom);
        c.s  = strb_t'($urandom);
        cq[r].push_back(c);
      end
    total = NR * NCMD;
    m_ph = 0; m_g = 0; exp_rv = '0; exp_rd = '0; exp_re = 1'b0; n_rsp = 0; cyc = 0;
    m_cur = cq[0][0];
    while (n_rsp < total && cyc < 3000) begin
      for (int r = 0; r < NR; r++) begin
        if (cq[r].size() != 0 && $urandom_range(0, 3) != 0) begin
          req_valid[r] = 1'b1;
          req_write[r] = cq[r][0].wr; req_addr[r] = cq[r][0].a;
          req_wdata[r] = cq[r][0].d;  req_strb[r] = cq[r][0].s;
        end else begin
          req_valid[r] = 1'b0;
          req_write[r] = 1'($urandom); req_addr[r] = addr_t'($urandom);
          req_wdata[r] = data_t'($urandom); req_strb[r] = strb_t'($urandom);
        end
      end
      @(negedge PCLK); cyc++;
      p = (m_ph == 0) ? pick(req_valid, m_last) : -1;
      exp_rdy = (p >= 0) ? oh(p) : '0;
      check("rnd_ready", 32'(req_ready), 32'(exp_rdy));
      check("rnd_rsp_vld", 32'(rsp_valid), 32'(exp_rv));
      if (rsp_valid != '0) n_rsp++;
      if (exp_rv != '0) begin
        check("rnd_rdata", rsp_rdata, exp_rd);
        check("rnd_err", 32'(rsp_err), 32'(exp_re));
      end
      if (m_ph == 1) begin
        check("rnd_setup", 32'({PSEL, PENABLE, PWRITE}), 32'({1'b1, 1'b0, m_cur.wr}));
        check("rnd_paddr", PADDR, m_cur.a);
        check("rnd_pwdata", PWDATA, m_cur.d);
        check("rnd_pstrb", 32'(PSTRB), m_cur.wr ? 32'(m_cur.s) : 32'(0));
      end else if (m_ph == 2) begin
        check("rnd_access", 32'({PSEL, PENABLE}), 32'h3);
        check("rnd_acc_paddr", PADDR, m_cur.a);
      end
      exp_rv = '0;
      if (m_ph == 0) begin
        if (p >= 0) begin
          m_g = p; m_cur = cq[p].pop_front(); m_last = p; m_ph = 1;
        end
      end else if (m_ph == 1) begin
        m_ph = 2;
      end else if (PREADY) begin
        exp_rv = oh(m_g);
        exp_re = slv_err;
        exp_rd = m_cur.wr ? 32'h0 : ref_mem[m_cur.a[5:2]];
        if (m_cur.wr && !slv_err) ref_mem[m_cur.a[5:2]] = merge(ref_mem[m_cur.a[5:2]], m_cur.d, m_cur.s);
        m_ph = 0;
      end
      @(posedge PCLK); #1;
    end
    check("rnd_rsp_count", 32'(n_rsp), 32'(total));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/apb_mst_arbiter.md
Name: apb_mst_arbiter

Overview:
- Round-robin arbiter and APB master sequencer.
- Shares one APB master port (drives the mst_mp signal set of apb_if) between NUM_REQ simple valid/ready command requesters.
- Runs the SETUP/ACCESS protocol, honours PREADY wait states, enforces an access timeout, and returns one response per command to the granted requester.
- Sits between on-chip command sources (test sequencer, CPU bridge, DMA) and the apb_dpmem slave.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYC, 16, max ACCESS cycles with PREADY=0 before forced abort; 0 disables the timeout.

Ports:
- PCLK  in  1  system clock.
- PRESETn  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  command valid per requester.
- req_ready  out  NUM_REQ  command accepted (one-hot or zero).
- req_addr  in  NUM_REQ x addr_t  command address.
- req_write  in  NUM_REQ  1=write, 0=read.
- req_wdata  in  NUM_REQ x data_t  write data.
- req_strb  in  NUM_REQ x strb_t  write strobes.
- rsp_valid  out  NUM_REQ  one-cycle response pulse to the owning requester.
- rsp_rdata  out  data_t  read data; shared, qualified by rsp_valid.
- rsp_err  out  1  PSLVERR or timeout; shared, qualified by rsp_valid.
- PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB  out  per apb_pkg types  APB master outputs.
- PREADY, PRDATA, PSLVERR  in  per apb_pkg types  APB slave responses.

Behaviour:
- Reset (async, PRESETn=0):
  - State=IDLE.
  - All outputs 0: PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, req_ready, rsp_valid, rsp_rdata, rsp_err.
  - last_grant=NUM_REQ-1, so requester 0 wins first.
  - Wait counter=0.
- Reset mid-transfer: the transfer is dropped silently and no rsp_valid is issued.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid is set, grant the first set index scanning from last_grant+1 with wrap-around.
  - req_ready[g] is combinational, high in this same cycle.
  - On the clock edge: capture addr/write/wdata/strb into the APB outputs, set last_grant=g, go to SETUP.
  - PSTRB is forced to 0 for reads.
  - With no req_valid set, stay in IDLE.
- SETUP: PSEL=1, PENABLE=0. Always advances to ACCESS after exactly one cycle.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=1: sample PRDATA (0 for writes) and PSLVERR; next cycle rsp_valid[g]=1 with rsp_rdata/rsp_err; go to IDLE.
  - PREADY=0: increment the wait counter.
  - If TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC: abort, go to IDLE; next cycle rsp_valid[g]=1, rsp_err=1, rsp_rdata=0.
  - The counter clears on every entry to SETUP.
- After a transfer, PSEL and PENABLE return to 0. PADDR, PWRITE, PWDATA and PSTRB hold their last values and are stable from SETUP through the end of ACCESS.
- Minimum latency: accept at T, SETUP T+1, ACCESS T+2 (PREADY=1), rsp_valid T+3. The next grant may occur at T+3 (SETUP T+4). No back-to-back ACCESS without an intervening IDLE.
- Requester changes to req_* after acceptance have no effect on the transfer in flight.
- Requests arriving during SETUP/ACCESS wait; req_ready stays 0 outside IDLE.
- Fairness: a continuously requesting source waits at most NUM_REQ-1 transfers.

Decomposition:
- apb_pkg: addr_t, data_t, strb_t, ADDR_WIDTH, DATA_WIDTH, and a new apb_state_e enum {IDLE, SETUP, ACCESS}.
- One sub-module: rr_arbiter. Combinational round-robin pick from (req vector, last_grant), returning a one-hot grant plus index. Reusable elsewhere.

Test Plan:
- Single write, req 0: addr=0x10, wdata=0xDEADBEEF, strb=0xF, PREADY tied 1 -> PSEL at T+1, PENABLE at T+2, rsp_valid[0] at T+3, rsp_err=0.
- Read with 3 wait states, slave returns 0x12345678 -> ACCESS lasts 4 cycles, PADDR stable throughout, rsp_rdata=0x12345678, PSTRB=0.
- Both requesters continuously valid, 6 commands -> grant order 0,1,0,1,0,1. Each transfer takes 3 cycles from one grant to the next.
- PREADY held 0, TIMEOUT_CYC=16 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0. The next request is accepted normally.
- Slave asserts PSLVERR with PREADY on a write to 0x3FC -> rsp_err=1 to the owning requester only; other rsp_valid bits stay 0.
- PRESETn pulsed low during ACCESS -> all outputs 0 immediately, no response issued, requester 0 granted first after release.
